// File: rtl/stall_flush_ctrl.sv
// Pipeline stall/flush controller: prioritised hazard handling with a 4-state FSM.
// Optional stalled-cycle counter enabled by defining STALL_PERF_CNT_EN.
module stall_flush_ctrl #(
  parameter int unsigned STALL_W = 6,
  parameter int unsigned PC_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_from_id,
  input  logic               stallreq_from_ex,
  input  logic               ex_done,
  input  logic               stallreq_from_mem,
  input  logic               mem_ready,
  input  logic               excp_req,
  input  logic [PC_W-1:0]    excp_pc,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [PC_W-1:0]    new_pc,
  output logic [1:0]         ctrl_state,
  output logic [31:0]        stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    EX_WAIT  = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  localparam logic [STALL_W-1:0] STALL_ID  = STALL_W'(3'b111);
  localparam logic [STALL_W-1:0] STALL_EX  = STALL_W'(4'b1111);
  localparam logic [STALL_W-1:0] STALL_MEM = STALL_W'(5'b11111);

  state_t            state_q, state_d;
  logic              flush_q;
  logic [PC_W-1:0]   new_pc_q;
  logic [STALL_W-1:0] stall_c;
  logic              capture_pc;

  always_comb begin
    state_d    = state_q;
    stall_c    = '0;
    capture_pc = 1'b0;
    case (state_q)
      RUN: begin
        if (excp_req) begin
          state_d    = FLUSH;
          capture_pc = 1'b1;
        end else if (stallreq_from_mem) begin
          stall_c = STALL_MEM;
          state_d = MEM_WAIT;
        end else if (stallreq_from_ex) begin
          stall_c = STALL_EX;
          state_d = EX_WAIT;
        end else if (stallreq_from_id) begin
          stall_c = STALL_ID;
        end
      end
      EX_WAIT: begin
        if (excp_req) begin
          state_d    = FLUSH;
          capture_pc = 1'b1;
        end else if (ex_done) begin
          state_d = RUN;
        end else begin
          stall_c = STALL_EX;
        end
      end
      MEM_WAIT: begin
        if (excp_req) begin
          state_d    = FLUSH;
          capture_pc = 1'b1;
        end else if (mem_ready) begin
          state_d = RUN;
        end else begin
          stall_c = STALL_MEM;
        end
      end
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
    // Reset masks the hold vector even though the FSM may still sit in a wait state.
    if (!rst) stall_c = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= RUN;
      flush_q  <= 1'b0;
      new_pc_q <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= (state_d == FLUSH);
      if (capture_pc) new_pc_q <= excp_pc;
    end
  end

  assign stall      = stall_c;
  assign flush      = flush_q;
  assign new_pc     = new_pc_q;
  assign ctrl_state = state_q;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if ((stall_c != '0) && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_stall_flush_ctrl.sv
// Self-checking bench for stall_flush_ctrl: directed scenarios plus random traffic
// checked against a rule-level reference model.
module tb_stall_flush_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_from_id, stallreq_from_ex, ex_done;
  logic        stallreq_from_mem, mem_ready, excp_req;
  logic [31:0] excp_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [1:0]  ctrl_state;
  logic [31:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  // Reference model: what the controller is waiting for, and the registered outputs.
  int          m_mode;   // 0 running, 1 waiting on EX, 2 waiting on MEM, 3 flushing
  logic        m_flush;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  stall_flush_ctrl #(.STALL_W(6), .PC_W(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_from_id  (stallreq_from_id),
    .stallreq_from_ex  (stallreq_from_ex),
    .ex_done           (ex_done),
    .stallreq_from_mem (stallreq_from_mem),
    .mem_ready         (mem_ready),
    .excp_req          (excp_req),
    .excp_pc           (excp_pc),
    .stall             (stall),
    .flush             (flush),
    .new_pc            (new_pc),
    .ctrl_state        (ctrl_state),
    .stall_cnt         (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] exp_stall(input bit r, input bit id, input bit ex,
                                           input bit exd, input bit mem, input bit mrdy,
                                           input bit excp);
    if (!r) return 6'h00;
    case (m_mode)
      0: begin
        if (excp)     return 6'h00;
        else if (mem) return 6'h1F;
        else if (ex)  return 6'h0F;
        else if (id)  return 6'h07;
        else          return 6'h00;
      end
      1:       return (excp || exd)  ? 6'h00 : 6'h0F;
      2:       return (excp || mrdy) ? 6'h00 : 6'h1F;
      default: return 6'h00;
    endcase
  endfunction

  task automatic step(input bit r, input bit id, input bit ex, input bit exd,
                      input bit mem, input bit mrdy, input bit excp, input logic [31:0] pc);
    logic [5:0] es;
    int nm;
    @(negedge clk);
    rst = r; stallreq_from_id = id; stallreq_from_ex = ex; ex_done = exd;
    stallreq_from_mem = mem; mem_ready = mrdy; excp_req = excp; excp_pc = pc;
    #1;
    es = exp_stall(r, id, ex, exd, mem, mrdy, excp);
    chk("stall", 64'(stall), 64'(es));
    chk("ctrl_state", 64'(ctrl_state), 64'(m_mode));
    chk("flush", 64'(flush), 64'(m_flush));
    chk("new_pc", 64'(new_pc), 64'(m_pc));
`ifdef STALL_PERF_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
`else
    chk("stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    @(posedge clk);
    if (!r) begin
      m_mode = 0; m_flush = 1'b0; m_pc = '0; m_cnt = '0;
    end else begin
      if (es != 6'h00 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      case (m_mode)
        0:       nm = excp ? 3 : mem ? 2 : ex ? 1 : 0;
        1:       nm = excp ? 3 : exd ? 0 : 1;
        2:       nm = excp ? 3 : mrdy ? 0 : 2;
        default: nm = 0;
      endcase
      if (nm == 3) m_pc = pc;
      m_flush = (nm == 3);
      m_mode  = nm;
    end
  endtask

  initial begin
    rst = 1'b0; stallreq_from_id = 1'b1; stallreq_from_ex = 1'b1; ex_done = 1'b1;
    stallreq_from_mem = 1'b1; mem_ready = 1'b1; excp_req = 1'b1; excp_pc = 32'h1234_5678;
    m_mode = 0; m_flush = 1'b0; m_pc = '0; m_cnt = '0;
    @(posedge clk);

    // Reset with every request asserted
    step(0, 1, 1, 1, 1, 1, 1, 32'h1234_5678);
    step(0, 1, 1, 1, 1, 1, 1, 32'h1234_5678);

    // Load-use stall
    step(1, 1, 0, 0, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 0, 0, 32'h0);

    // Multi-cycle EX: done after five stalled cycles; ex level and id ignored while waiting
    step(1, 0, 1, 0, 0, 0, 0, 32'h0);
    step(1, 1, 1, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 32'h0);
    step(1, 0, 0, 1, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 0, 0, 32'h0);

    // Exception during MEM wait
    step(1, 0, 0, 0, 1, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 0, 1, 32'hBFC0_0380);
    step(1, 0, 0, 0, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 0, 0, 32'h0);

    // Completion pulses in RUN are ignored
    step(1, 0, 0, 1, 0, 1, 0, 32'h0);

    // All requests at once; FLUSH ignores ex_done and a second exception
    step(1, 1, 1, 0, 1, 0, 1, 32'h8000_0180);
    step(1, 1, 1, 1, 1, 1, 1, 32'hDEAD_BEEF);
    step(1, 0, 0, 0, 0, 0, 0, 32'h0);

    // Reset aborts a MEM wait
    step(1, 0, 0, 0, 1, 0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 0, 0, 32'h0);

`ifdef STALL_PERF_CNT_EN
    // Saturation: preload counter near the top and hold a MEM stall
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    m_cnt = 32'hFFFF_FFFD;
    step(1, 0, 0, 0, 1, 0, 0, 32'h0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 1, 0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 32'h0);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(29) != 0),
           ($urandom_range(2) == 0),
           ($urandom_range(4) == 0),
           ($urandom_range(3) == 0),
           ($urandom_range(5) == 0),
           ($urandom_range(3) == 0),
           ($urandom_range(11) == 0),
           $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stall_flush_ctrl.md
STALL_FLUSH_CTRL -- requirements
Module: stall_flush_ctrl

Interface
REQ-001 SHALL have parameter STALL_W, default 6, width of stall vector; bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
REQ-002 SHALL have parameter PC_W, default 32, width of excp_pc and new_pc.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 stallreq_from_id  input  1  load-use hazard; single-cycle stall request.
REQ-006 stallreq_from_ex  input  1  multi-cycle EX operation started; level, sampled once.
REQ-007 ex_done  input  1  multi-cycle EX result valid; one-cycle pulse.
REQ-008 stallreq_from_mem  input  1  data-bus access not yet accepted.
REQ-009 mem_ready  input  1  data-bus access complete; one-cycle pulse.
REQ-010 excp_req  input  1  exception/redirect request.
REQ-011 excp_pc  input  PC_W  redirect target, valid with excp_req.
REQ-012 stall  output  STALL_W  per-stage hold vector, combinational from state and inputs.
REQ-013 flush  output  1  pipeline flush pulse, registered.
REQ-014 new_pc  output  PC_W  redirect target, registered, valid while flush=1.
REQ-015 ctrl_state  output  2  current FSM state (debug).
REQ-016 stall_cnt  output  32  stalled-cycle count (see Configuration).

Function
REQ-017 States SHALL be RUN=0, EX_WAIT=1, MEM_WAIT=2, FLUSH=3.
REQ-018 Input priority SHALL be excp_req > stallreq_from_mem > stallreq_from_ex > stallreq_from_id.
REQ-019 RUN: excp_req -> stall=0, next FLUSH, new_pc<=excp_pc; else mem req -> stall=011111, next MEM_WAIT; else ex req -> stall=001111, next EX_WAIT; else id req -> stall=000111, stay RUN; else stall=0.
REQ-020 EX_WAIT: excp_req -> stall=0, next FLUSH (wait abandoned); else ex_done -> stall=0, next RUN; else stall=001111, stay.
REQ-021 MEM_WAIT: excp_req -> stall=0, next FLUSH; else mem_ready -> stall=0, next RUN; else stall=011111, stay.
REQ-022 FLUSH: flush=1 for exactly one cycle, stall=0, all requests ignored, next RUN unconditionally.
REQ-023 flush SHALL be 1 only in FLUSH state; new_pc SHALL hold its value until the next excp_req capture.
REQ-024 Exception-to-flush latency SHALL be 1 cycle (excp_req at cycle N -> flush=1 at N+1).
REQ-025 ex_done/mem_ready arriving in RUN SHALL be ignored; stallreq_from_id in EX_WAIT/MEM_WAIT SHALL be ignored.
REQ-026 excp_req in FLUSH SHALL be ignored; it is not queued.

Reset
REQ-027 While rst=0 at a clock edge: state<=RUN, flush<=0, new_pc<=0, stall_cnt<=0.
REQ-028 While rst=0, stall SHALL be 0 regardless of inputs.
REQ-029 Reset during EX_WAIT/MEM_WAIT/FLUSH SHALL abort the operation; first cycle after release is RUN with stall=0 unless a request is present.

Configuration
REQ-030 Macro STALL_PERF_CNT_EN defined: stall_cnt increments by 1 each cycle with rst=1 and stall!=0, saturating at 32'hFFFFFFFF.
REQ-031 Macro STALL_PERF_CNT_EN undefined: stall_cnt port present, tied to 0, no counter register.

Verification
REQ-032 Reset: rst=0 two cycles with all requests=1 -> stall=0, flush=0, new_pc=0, ctrl_state=0.
REQ-033 Load-use: stallreq_from_id=1 one cycle -> stall=000111 that cycle, ctrl_state stays 0, next cycle stall=0.
REQ-034 Divide: stallreq_from_ex=1 at cycle 0, ex_done at cycle 5 -> stall=001111 cycles 0-4, stall=0 cycle 5, ctrl_state=0 cycle 6; stall_cnt=5 (macro on).
REQ-035 Exception mid-wait: mem req cycle 0, excp_req with excp_pc=0xBFC00380 cycle 3 -> stall=011111 cycles 0-2, stall=0 cycle 3, flush=1 and new_pc=0xBFC00380 cycle 4 only.
REQ-036 Simultaneous: excp_req, mem, ex, id all=1 in RUN -> stall=0, next state FLUSH; ex_done during FLUSH ignored.
REQ-037 Saturation (macro on): preload counter near max, sustain stall -> stall_cnt holds 32'hFFFFFFFF; macro off -> stall_cnt=0 throughout.
